fetch_pc: RTL and testbench

IF-stage program counter and IF/ID pipeline register: the consumer of the EX-stage branch target. Each cycle the block issues an instruction-memory address and passes PC+4 (`ID_npc`) down the pipeline, where it becomes the base operand of the branch-target adder. It accepts the resulting `EX_bpc` back from EX, redirects fetch, and squashes wrong-path instructions. It also honours hazard stalls from ID.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_pc_if.sv | 25 ++
 rtl/add_npc.sv | 12 +
 rtl/fetch_pc.sv | 105 ++++++++++
 tb/tb_fetch_pc.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage.
// Holds the fetch FSM encoding and the PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RESET    = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'h0;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch-stage bundle: EX redirect, ID stall, imem data and IF/ID outputs.
// master is the fetch unit, slave is the surrounding pipeline.
interface fetch_pc_if;

    logic [31:0] EX_bpc;
    logic        EX_take;
    logic        ID_stall;
    logic [31:0] IM_data;
    logic [31:0] IF_pc;
    logic [31:0] ID_npc;
    logic [31:0] ID_instr;
    logic        ID_valid;
    logic        IF_flush;

    modport master (
        input  EX_bpc, EX_take, ID_stall, IM_data,
        output IF_pc, ID_npc, ID_instr, ID_valid, IF_flush
    );

    modport slave (
        output EX_bpc, EX_take, ID_stall, IM_data,
        input  IF_pc, ID_npc, ID_instr, ID_valid, IF_flush
    );

endinterface

// File: rtl/add_npc.sv
// Sequential-path incrementer: npc = pc + 4, modulo 2^32.
// Sibling of the EX branch-target adder that consumes ID_npc.
module add_npc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] npc
);

    assign npc = pc + PC_INC;

endmodule

// File: rtl/fetch_pc.sv
// IF-stage PC register, IF/ID pipeline register and fetch FSM.
// Define FETCH_PC_DELAY_SLOT_EN to keep the ID instruction on a taken branch.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst_n,
    fetch_pc_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  id_npc_q, id_npc_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  npc;
    logic         live;
    logic         take;
    logic         stall;

    add_npc u_add_npc (
        .pc  (pc_q),
        .npc (npc)
    );

    // Nothing is fetched or redirected until the FSM leaves RESET.
    assign live  = (state_q != ST_RESET);
    assign take  = live & bus.EX_take;
    assign stall = live & bus.ID_stall;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN: begin
                if (take)       state_d = ST_REDIRECT;
                else if (stall) state_d = ST_STALL;
            end
            ST_STALL: begin
                if (take)       state_d = ST_REDIRECT;
                else if (!stall) state_d = ST_RUN;
            end
            ST_REDIRECT: begin
                if (take)       state_d = ST_REDIRECT;
                else if (stall) state_d = ST_STALL;
                else            state_d = ST_RUN;
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        id_npc_d   = id_npc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (take) begin
            pc_d = align_pc(bus.EX_bpc);
        end else if (live && !stall) begin
            pc_d = npc;
        end
`ifdef FETCH_PC_DELAY_SLOT_EN
        if (live && !stall) begin
            id_npc_d   = npc;
            id_instr_d = bus.IM_data;
            id_valid_d = 1'b1;
        end
`else
        if (take) begin
            id_npc_d   = 32'h0;
            id_instr_d = NOP_WORD;
            id_valid_d = 1'b0;
        end else if (live && !stall) begin
            id_npc_d   = npc;
            id_instr_d = bus.IM_data;
            id_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            pc_q       <= RESET_VECTOR;
            id_npc_q   <= 32'h0;
            id_instr_q <= NOP_WORD;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_npc_q   <= id_npc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign bus.IF_pc    = pc_q;
    assign bus.ID_npc   = id_npc_q;
    assign bus.ID_instr = id_instr_q;
    assign bus.ID_valid = id_valid_q;
    assign bus.IF_flush = take;

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc with RESET_VECTOR = 0x100.
// Stimulus queues expected responses; a monitor compares them each cycle.
module tb_fetch_pc;

    logic clk;
    logic rst_n;

    fetch_pc_if bus ();

    fetch_pc #(.RESET_VECTOR(32'h100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] instr;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   vid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, a, e);
        end
    endtask

    task automatic vec_nw(input logic tk, input logic [31:0] bpc,
                          input logic st, input logic [31:0] im,
                          input logic ef, input logic [31:0] epc,
                          input logic [31:0] enpc, input logic [31:0] einstr,
                          input logic ev);
        exp_t e;
        bus.EX_take  = tk;
        bus.EX_bpc   = bpc;
        bus.ID_stall = st;
        bus.IM_data  = im;
        e.id    = vid;
        e.flush = ef;
        e.pc    = epc;
        e.npc   = enpc;
        e.instr = einstr;
        e.valid = ev;
        sb.push_back(e);
        vid++;
    endtask

    task automatic vec(input logic tk, input logic [31:0] bpc,
                       input logic st, input logic [31:0] im,
                       input logic ef, input logic [31:0] epc,
                       input logic [31:0] enpc, input logic [31:0] einstr,
                       input logic ev);
        @(negedge clk);
        #1;
        vec_nw(tk, bpc, st, im, ef, epc, enpc, einstr, ev);
    endtask

    // Monitor: flush is checked mid-cycle, registers just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb[0];
                chk($sformatf("v%0d flush", e.id), {31'b0, bus.IF_flush},
                    {31'b0, e.flush});
                @(posedge clk);
                #1;
                chk($sformatf("v%0d pc", e.id), bus.IF_pc, e.pc);
                chk($sformatf("v%0d npc", e.id), bus.ID_npc, e.npc);
                chk($sformatf("v%0d instr", e.id), bus.ID_instr, e.instr);
                chk($sformatf("v%0d valid", e.id), {31'b0, bus.ID_valid},
                    {31'b0, e.valid});
                void'(sb.pop_front());
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, " pc"}, bus.IF_pc, 32'h100);
        chk({tag, " npc"}, bus.ID_npc, 32'h0);
        chk({tag, " instr"}, bus.ID_instr, 32'h0);
        chk({tag, " valid"}, {31'b0, bus.ID_valid}, 32'h0);
        chk({tag, " flush"}, {31'b0, bus.IF_flush}, 32'h0);
    endtask

    task automatic start_seq();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        vec_nw(0, 0, 0, 32'h01, 0, 32'h100, 32'h0, 32'h0, 0);
        vec(0, 0, 0, 32'h11, 0, 32'h104, 32'h104, 32'h11, 1);
        vec(0, 0, 0, 32'h22, 0, 32'h108, 32'h108, 32'h22, 1);
    endtask

    initial begin
        int budget;
        checks = 0;
        errors = 0;
        vid = 0;
        rst_n = 1'b0;
        bus.EX_take  = 1'b0;
        bus.EX_bpc   = 32'h0;
        bus.ID_stall = 1'b0;
        bus.IM_data  = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        bus.EX_take = 1'b1;
        #1;
        check_reset("rst0");
        bus.EX_take = 1'b0;

        start_seq();
        vec(0, 0, 0, 32'h2A, 0, 32'h10C, 32'h10C, 32'h2A, 1);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("rst1");
        start_seq();

        vec(0, 0, 1, 32'h33, 0, 32'h108, 32'h108, 32'h22, 1);
        vec(0, 0, 1, 32'h33, 0, 32'h108, 32'h108, 32'h22, 1);
        vec(0, 0, 1, 32'h33, 0, 32'h108, 32'h108, 32'h22, 1);
        vec(0, 0, 0, 32'h33, 0, 32'h10C, 32'h10C, 32'h33, 1);
        vec(0, 0, 0, 32'h44, 0, 32'h110, 32'h110, 32'h44, 1);
`ifdef FETCH_PC_DELAY_SLOT_EN
        vec(1, 32'h400, 0, 32'h55, 1, 32'h400, 32'h114, 32'h55, 1);
        vec(0, 0, 0, 32'h66, 0, 32'h404, 32'h404, 32'h66, 1);
        vec(1, 32'h203, 1, 32'h77, 1, 32'h200, 32'h404, 32'h66, 1);
        vec(1, 32'hFFFF_FFFC, 0, 32'h88, 1, 32'hFFFF_FFFC,
            32'h204, 32'h88, 1);
        vec(0, 0, 0, 32'h99, 0, 32'h0, 32'h0, 32'h99, 1);
        vec(0, 0, 1, 32'hAA, 0, 32'h0, 32'h0, 32'h99, 1);
        vec(1, 32'h300, 1, 32'hAA, 1, 32'h300, 32'h0, 32'h99, 1);
        vec(0, 0, 1, 32'hAA, 0, 32'h300, 32'h0, 32'h99, 1);
`else
        vec(1, 32'h400, 0, 32'h55, 1, 32'h400, 32'h0, 32'h0, 0);
        vec(0, 0, 0, 32'h66, 0, 32'h404, 32'h404, 32'h66, 1);
        vec(1, 32'h203, 1, 32'h77, 1, 32'h200, 32'h0, 32'h0, 0);
        vec(1, 32'hFFFF_FFFC, 0, 32'h88, 1, 32'hFFFF_FFFC,
            32'h0, 32'h0, 0);
        vec(0, 0, 0, 32'h99, 0, 32'h0, 32'h0, 32'h99, 1);
        vec(0, 0, 1, 32'hAA, 0, 32'h0, 32'h0, 32'h99, 1);
        vec(1, 32'h300, 1, 32'hAA, 1, 32'h300, 32'h0, 32'h0, 0);
        vec(0, 0, 1, 32'hAA, 0, 32'h300, 32'h0, 32'h0, 0);
`endif
        vec(0, 0, 0, 32'hBB, 0, 32'h304, 32'h304, 32'hBB, 1);

        budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left %0d entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
